mips_fetch_unit: RTL and testbench

//  Instruction-fetch and PC stage for the MIPS core, directly upstream of the main controller.

---
 rtl/mips_fetch_unit.sv | 79 +++++++
 tb/tb_mips_fetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch / PC stage: fetches a word over a req/ready handshake, holds it for the
// controller, then steps the PC to PC+4, the branch target or the jump target.
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    input  logic             step,
    input  logic             pcsrc,
    input  logic             jump,
    input  logic [31:0]      signimm,
    output logic [31:0]      instr,
    output logic [5:0]       op,
    output logic [5:0]       funct,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pcplus4,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

    state_t      state, state_nxt;
    logic        fetch_done, retire;
    logic [31:0] pcbranch, pcjump, pcnext;

    assign fetch_done = (state == FETCH) && imem_ready;
    assign retire     = (state == HOLD) && step;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= FETCH;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (imem_ready) state_nxt = HOLD;
            HOLD:    if (step)       state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        imem_req    = (state == FETCH);
        instr_valid = (state == HOLD);
    end

    // Branch/jump targets stay word aligned, so pc[1:0] never leaves 00.
    assign pcplus4  = pc + 32'd4;
    assign pcbranch = pcplus4 + (signimm << 2);
    assign pcjump   = {pcplus4[31:28], instr[25:0], 2'b00};
    assign pcnext   = jump ? pcjump : (pcsrc ? pcbranch : pcplus4);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= RESET_PC;
            retired <= '0;
        end else if (retire) begin
            pc      <= pcnext;
            retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        instr <= '0;
        else if (fetch_done) instr <= imem_rdata;
    end

    assign imem_addr = pc;
    assign op        = instr[31:26];
    assign funct     = instr[5:0];

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: an instruction-level model checked against the DUT
// every cycle, plus literal expectations for the fetch/branch/jump/stall/reset scenarios.
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req, imem_ready, instr_valid;
    logic [31:0] imem_addr, imem_rdata, instr, pc, pcplus4, signimm;
    logic [5:0]  op, funct;
    logic        step = 1'b0, pcsrc = 1'b0, jump = 1'b0;
    logic [31:0] retired;

    int vectors = 0, miscompares = 0;
    int mem_delay = 0;
    int wait_cnt;
    bit chk_en = 1'b0;

    // Instruction-level model: which phase we are in, current pc/word, retired count
    bit          m_hold;
    logic [31:0] m_pc, m_instr, m_ret, m_next;

    always #5 clk = ~clk;

    mips_fetch_unit #(.RESET_PC(32'h0), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .step(step), .pcsrc(pcsrc), .jump(jump), .signimm(signimm),
        .instr(instr), .op(op), .funct(funct), .instr_valid(instr_valid),
        .pc(pc), .pcplus4(pcplus4), .retired(retired)
    );

    // Program image: beq at 0x10, j at 0x4000_0020, lw-like words elsewhere
    function automatic logic [31:0] rdata_for(input logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'h1000_FFFE;
            32'h4000_0020: return 32'h0800_0100;
            default:       return 32'h8C00_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    assign imem_rdata = rdata_for(imem_addr);
    assign imem_ready = imem_req && (wait_cnt >= mem_delay);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)                     wait_cnt <= 0;
        else if (imem_req && !imem_ready) wait_cnt <= wait_cnt + 1;
        else                              wait_cnt <= 0;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hold <= 1'b0; m_pc <= 32'h0; m_instr <= 32'h0; m_ret <= 32'h0;
        end else if (!m_hold) begin
            if (imem_ready) begin m_instr <= imem_rdata; m_hold <= 1'b1; end
        end else if (step) begin
            if (jump)       m_next = {m_pc[31:28] + ((m_pc + 32'd4) >> 28) - m_pc[31:28],
                                      m_instr[25:0], 2'b00};
            else if (pcsrc) m_next = m_pc + 32'd4 + signimm * 32'd4;
            else            m_next = m_pc + 32'd4;
            m_pc   <= m_next;
            m_ret  <= m_ret + 32'd1;
            m_hold <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_req",    {31'h0, imem_req},    {31'h0, !m_hold});
            chk("instr_valid", {31'h0, instr_valid}, {31'h0, m_hold});
            chk("imem_addr",   imem_addr, m_pc);
            chk("pc",          pc,        m_pc);
            chk("pcplus4",     pcplus4,   m_pc + 32'd4);
            chk("instr",       instr,     m_instr);
            chk("op",          {26'h0, op},    {26'h0, m_instr[31:26]});
            chk("funct",       {26'h0, funct}, {26'h0, m_instr[5:0]});
            chk("retired",     retired,   m_ret);
        end
    end

    task automatic wait_valid();
        int n = 0;
        while (!instr_valid && n < 20) begin @(negedge clk); n++; end
        chk("wait_valid_timeout", {31'h0, instr_valid}, 32'h1);
    endtask

    // Called at a negedge in HOLD; returns at the negedge after the PC update
    task automatic retire_instr(input logic ps, input logic jp, input logic [31:0] simm);
        step = 1'b1; pcsrc = ps; jump = jp; signimm = simm;
        @(posedge clk); #1;
        step = 1'b0; pcsrc = 1'b0; jump = 1'b0; signimm = 32'h0;
        @(negedge clk);
    endtask

    initial begin
        signimm = 32'h0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_req",   {31'h0, imem_req},    32'h1);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_op",    {26'h0, op},          32'h0);
        chk("rst_instr", instr,                32'h0);
        #2 reset_n = 1'b1;
        @(negedge clk);

        // Straight-line code, zero-wait memory
        for (int i = 0; i < 4; i++) begin
            chk("seq_addr", imem_addr, i * 4);
            wait_valid();
            retire_instr(1'b0, 1'b0, 32'h0);
        end
        chk("seq_retired", retired, 32'd4);

        // beq at 0x10: taken goes back to 0x0C, not-taken goes to 0x14
        chk("beq_addr", imem_addr, 32'h10);
        wait_valid();
        chk("beq_op", {26'h0, op}, 32'h4);
        retire_instr(1'b1, 1'b0, 32'hFFFF_FFFE);
        chk("beq_taken", imem_addr, 32'h0C);
        wait_valid();
        retire_instr(1'b0, 1'b0, 32'h0);
        wait_valid();
        retire_instr(1'b0, 1'b0, 32'hFFFF_FFFE);
        chk("beq_not_taken", imem_addr, 32'h14);

        // Long branch to the jump, then jump with pcsrc also set
        wait_valid();
        retire_instr(1'b1, 1'b0, 32'h1000_0002);
        chk("far_branch", imem_addr, 32'h4000_0020);
        wait_valid();
        chk("j_op", {26'h0, op}, 32'h2);
        retire_instr(1'b1, 1'b1, 32'h5);
        chk("j_target", pc, 32'h4000_0400);

        // Stall in HOLD for 5 cycles
        wait_valid();
        repeat (5) @(negedge clk);
        chk("stall_instr",   instr,   32'h8C00_0400);
        chk("stall_op",      {26'h0, op},    32'h23);
        chk("stall_funct",   {26'h0, funct}, 32'h0);
        chk("stall_pc",      pc,      32'h4000_0400);
        chk("stall_retired", retired, 32'd9);

        // Slow memory: 3 wait cycles, step pulsed during FETCH must be ignored
        mem_delay = 3;
        retire_instr(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            chk("slow_req",   {31'h0, imem_req},    32'h1);
            chk("slow_addr",  imem_addr,            32'h4000_0404);
            chk("slow_valid", {31'h0, instr_valid}, 32'h0);
            step = (k < 3);
            @(negedge clk);
        end
        step = 1'b0;
        chk("slow_valid_rise", {31'h0, instr_valid}, 32'h1);
        @(negedge clk);
        chk("slow_no_queue", retired, 32'd10);

        // Asynchronous reset in the middle of a slow fetch
        retire_instr(1'b0, 1'b0, 32'h0);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("arst_pc",      pc,                   32'h0);
        chk("arst_valid",   {31'h0, instr_valid}, 32'h0);
        chk("arst_retired", retired,              32'h0);
        mem_delay = 0;
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("restart_addr", imem_addr, 32'h0);
        wait_valid();
        chk("restart_instr", instr, 32'h8C00_0000);
        retire_instr(1'b0, 1'b0, 32'h0);
        chk("restart_retired", retired, 32'd1);
        @(negedge clk);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
